mem_loader: RTL

- Streaming loader that writes program and data images into IM and DM through their byte-enable write ports, using the same address/data/w_en convention the CPU drives on DM.
- Accepts a byte stream (valid/ready), parses framed load records, and writes one 32-bit little-endian word per record beat.
- Holds the CPU in reset until the final frame has been written plus a programmable hold-off.
- Sits between an external byte source (UART/host model) and the IM/DM write ports, in front of CPU rst.

---
 rtl/mem_loader_pkg.sv | 38 +++
 rtl/mem_loader_word_assembler.sv | 30 +++
 rtl/mem_loader.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/mem_loader_pkg.sv
// Shared definitions for the streaming memory loader: FSM states, header
// field positions and write-target codes.
package mem_loader_pkg;

  typedef enum logic [3:0] {
    ST_HDR,
    ST_ADDR_LO,
    ST_ADDR_HI,
    ST_CNT_LO,
    ST_CNT_HI,
    ST_DATA,
    ST_WRITE,
    ST_HOLD,
    ST_DONE,
    ST_ERROR
  } state_t;

  localparam int         TGT_BIT       = 0;
  localparam int         LAST_BIT      = 7;
  localparam logic [7:0] HDR_RSVD_MASK = 8'h7E;

  localparam logic TGT_IM = 1'b0;
  localparam logic TGT_DM = 1'b1;

  localparam logic [3:0] WORD_EN = 4'b1111;

  // States in which a stream byte may be consumed.
  function automatic logic accepts_input(input state_t s);
    logic ok;
    ok = 1'b0;
    case (s)
      ST_HDR, ST_ADDR_LO, ST_ADDR_HI, ST_CNT_LO, ST_CNT_HI, ST_DATA: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_loader_word_assembler.sv
// Collects four stream bytes into a little-endian 32-bit word; the first
// byte received ends up in bits [7:0].
module word_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_full
);

  logic [1:0]  byte_cnt_reg;
  logic [31:0] word_reg;

  // High when the byte being shifted in this cycle completes the word.
  assign word_full = shift_en && (byte_cnt_reg == 2'd3);
  assign word      = word_reg;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      byte_cnt_reg <= 2'd0;
      word_reg     <= 32'h0;
    end else if (shift_en) begin
      byte_cnt_reg <= byte_cnt_reg + 2'd1;
      word_reg     <= {byte_in, word_reg[31:8]};
    end
  end

endmodule

// File: rtl/mem_loader.sv
// Parses framed load records from a byte stream, writes words into IM/DM and
// keeps the CPU in reset until the final frame plus a hold-off has elapsed.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic [3:0]  im_w_en,
  output logic [3:0]  dm_w_en,
  output logic [15:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        cpu_rst,
  output logic        load_done,
  output logic        load_err
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  state_t              state_reg, state_next;
  state_t              frame_end_state;
  logic [15:0]         addr_reg, addr_next;
  logic [15:0]         remaining_reg, remaining_next;
  logic                tgt_reg, tgt_next;
  logic                last_reg, last_next;
  logic [HOLD_W-1:0]   hold_cnt_reg, hold_cnt_next;
  logic                in_ready_reg;
  logic [3:0]          im_w_en_reg, dm_w_en_reg;
  logic                cpu_rst_reg, load_done_reg, load_err_reg;

  logic                xfer;
  logic                asm_clear, asm_shift, word_full;
  logic [31:0]         word;
  logic [15:0]         count_in;

  assign xfer      = in_valid && in_ready_reg;
  assign asm_shift = (state_reg == ST_DATA) && xfer;
  assign asm_clear = (state_reg == ST_HDR) || (state_reg == ST_WRITE);
  // CNT_LO is parked in the low byte of the remaining counter until CNT_HI arrives.
  assign count_in  = {in_data, remaining_reg[7:0]};

  word_assembler u_word_assembler (
    .clk       (clk),
    .rst       (rst),
    .clear     (asm_clear),
    .shift_en  (asm_shift),
    .byte_in   (in_data),
    .word      (word),
    .word_full (word_full)
  );

  always_comb begin
    frame_end_state = ST_HDR;
    if (last_reg) begin
      frame_end_state = (HOLD_CYCLES == 0) ? ST_DONE : ST_HOLD;
    end
  end

  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    remaining_next = remaining_reg;
    tgt_next       = tgt_reg;
    last_next      = last_reg;
    hold_cnt_next  = hold_cnt_reg;

    case (state_reg)
      ST_HDR: begin
        if (xfer) begin
          if ((in_data & HDR_RSVD_MASK) != 8'h00) begin
            state_next = ST_ERROR;
          end else begin
            tgt_next   = in_data[TGT_BIT];
            last_next  = in_data[LAST_BIT];
            state_next = ST_ADDR_LO;
          end
        end
      end
      ST_ADDR_LO: begin
        if (xfer) begin
          addr_next  = {addr_reg[15:8], in_data[7:2], 2'b00};
          state_next = ST_ADDR_HI;
        end
      end
      ST_ADDR_HI: begin
        if (xfer) begin
          addr_next  = {in_data, addr_reg[7:0]};
          state_next = ST_CNT_LO;
        end
      end
      ST_CNT_LO: begin
        if (xfer) begin
          remaining_next = {remaining_reg[15:8], in_data};
          state_next     = ST_CNT_HI;
        end
      end
      ST_CNT_HI: begin
        if (xfer) begin
          remaining_next = count_in;
          hold_cnt_next  = '0;
          state_next     = (count_in != 16'd0) ? ST_DATA : frame_end_state;
        end
      end
      ST_DATA: begin
        if (word_full) begin
          state_next = ST_WRITE;
        end
      end
      ST_WRITE: begin
        addr_next      = addr_reg + 16'd4;
        remaining_next = remaining_reg - 16'd1;
        hold_cnt_next  = '0;
        state_next     = (remaining_reg != 16'd1) ? ST_DATA : frame_end_state;
      end
      ST_HOLD: begin
        if (hold_cnt_reg == HOLD_W'(HOLD_CYCLES - 1)) begin
          state_next = ST_DONE;
        end else begin
          hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
        end
      end
      ST_DONE, ST_ERROR: begin
        state_next = state_reg;
      end
      default: begin
        state_next = ST_HDR;
      end
    endcase
  end

  // Handshake and status flags are decoded from the next state so they line
  // up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_HDR;
      addr_reg      <= 16'h0;
      remaining_reg <= 16'h0;
      tgt_reg       <= TGT_IM;
      last_reg      <= 1'b0;
      hold_cnt_reg  <= '0;
      in_ready_reg  <= 1'b0;
      im_w_en_reg   <= 4'h0;
      dm_w_en_reg   <= 4'h0;
      cpu_rst_reg   <= 1'b1;
      load_done_reg <= 1'b0;
      load_err_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      remaining_reg <= remaining_next;
      tgt_reg       <= tgt_next;
      last_reg      <= last_next;
      hold_cnt_reg  <= hold_cnt_next;
      in_ready_reg  <= accepts_input(state_next);
      im_w_en_reg   <= (state_next == ST_WRITE && tgt_next == TGT_IM) ? WORD_EN : 4'h0;
      dm_w_en_reg   <= (state_next == ST_WRITE && tgt_next == TGT_DM) ? WORD_EN : 4'h0;
      cpu_rst_reg   <= (state_next != ST_DONE);
      load_done_reg <= (state_next == ST_DONE);
      load_err_reg  <= (state_next == ST_ERROR);
    end
  end

  assign in_ready       = in_ready_reg;
  assign im_w_en        = im_w_en_reg;
  assign dm_w_en        = dm_w_en_reg;
  assign mem_address    = addr_reg;
  assign mem_write_data = word;
  assign cpu_rst        = cpu_rst_reg;
  assign load_done      = load_done_reg;
  assign load_err       = load_err_reg;

endmodule
